axi_write_vector: RTL and testbench
===================================

Name: axi_write_vector

Overview:
Serialises a captured bit vector of run-time length into AXI-stream chunks of AXI_DATA_WIDTH bits, least significant chunk first. It is the producer feeding the vector-reader stage: it drives the same axi_stream_if from the master side, so a vector can be moved between solver stages, or looped back in test, as a stream. It runs one transfer per start pulse and flags completion with a one-cycle done pulse.

Parameters:
MAX_VEC_LENGTH, 64, maximum vector length in bits; width of vec.
AXI_DATA_WIDTH, 8, stream beat width in bits.
LEN_W, $clog2(MAX_VEC_LENGTH+1), width of vec_length (derived; do not override).

Ports:
clk  input  1  sole clock; all state updates on its rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  request to capture vec/vec_length and begin a transfer; honoured only in IDLE.
vec_length  input  LEN_W  number of valid bits in vec, counted from bit 0.
vec  input  MAX_VEC_LENGTH  vector to send; sampled only on an accepted start.
data_out  axi_stream_if master  AXI_DATA_WIDTH  drives tvalid, tdata, tlast; samples tready.
idle  output  1  high in IDLE, i.e. when start will be accepted.
done  output  1  one-cycle pulse after the last beat's handshake.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, idle=1, done=0, tvalid=0, tlast=0, chunk counter=0. tdata is don't-care while tvalid=0; drive it to 0.
- States: IDLE, SEND, DONE.
  - IDLE: idle=1. On start, go to SEND.
  - SEND: tvalid=1. On handshake (tvalid && tready) of the final chunk, go to DONE; otherwise stay.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Start with vec_length==0: go IDLE->DONE directly. No beats are sent; done is asserted the cycle after start.
- Capture on accepted start:
  - eff_len = min(vec_length, MAX_VEC_LENGTH).
  - Register vec into an internal buffer of MAX_CHUNKS*AXI_DATA_WIDTH bits, where MAX_CHUNKS = ceil(MAX_VEC_LENGTH/AXI_DATA_WIDTH).
  - Bits at positions >= eff_len are zeroed. The padding above MAX_VEC_LENGTH is zero.
  - last_chunk = ceil(eff_len/AXI_DATA_WIDTH) - 1. Compute this in at least LEN_W+1 bits to avoid overflow.
- Latency: start sampled at cycle t gives tvalid=1 with chunk 0 at cycle t+1.
- Beat contents: tdata = buffer[chunk*W +: W]; tlast = (chunk == last_chunk).
- Handshake rules:
  - While tvalid && !tready, tdata, tlast and tvalid hold stable (AXI rule).
  - tvalid never depends combinationally on tready.
  - The chunk counter increments only on handshake.
- Back-to-back operation: after done, the next start is accepted in the following IDLE cycle. The minimum gap between transfers is 1 idle cycle.
- start asserted in SEND or DONE is ignored. The vec and vec_length inputs may change freely after capture.
- Chunk counter width: max(1, $clog2(MAX_CHUNKS)). It never exceeds last_chunk, and it resets to 0 on each accepted start.
- Reset mid-transfer: the next cycle shows tvalid=0, idle=1, done=0, with no partial tlast. The downstream is responsible for its own reset.

Decomposition:
- Shared package vec_stream_pkg holds:
  - function num_chunks(len, width) returning ceil(len/width);
  - localparam helpers for MAX_CHUNKS and the counter width, so reader and writer agree.
- The state enum stays local to the module.
- No sub-module is needed. The masking and chunk select are small enough to stay inline.

Test Plan:
(MAX_VEC_LENGTH=20, AXI_DATA_WIDTH=8)
1. vec=20'hABCDE, len=20, tready=1 -> beats 0xDE, 0xBC, 0x0A on cycles t+1..t+3; tlast on the 3rd beat only; done at t+4; idle at t+5.
2. Same vec, tready=0 for 2 cycles while beat 1 is presented -> tdata holds 0xBC and tvalid stays 1 for 3 cycles; no beat is lost or duplicated; done 1 cycle after the 0x0A handshake.
3. vec=20'hFFFFF, len=5 -> single beat 0x1F with tlast=1; upper bits are masked to 0.
4. len=0 with start -> no tvalid at any time; done=1 at t+1; idle at t+2. len=25 (greater than MAX) -> behaves as len=20.
5. start pulsed with a new vec during SEND of scenario 1 -> ignored; the beat sequence is unchanged.
6. rst asserted after the first handshake -> tvalid=0 and idle=1 next cycle. A following start with len=8, vec=0x5A gives a single beat 0x5A with tlast=1.

Source files
------------

// File: rtl/vec_stream_pkg.sv
// Shared sizing helpers for the vector stream reader/writer pair.
// Both sides derive chunk counts from the same functions.
package vec_stream_pkg;

    function automatic int num_chunks(input int len, input int width);
        return (len + width - 1) / width;
    endfunction

    function automatic int max_chunks(input int max_len, input int width);
        return num_chunks(max_len, width);
    endfunction

    function automatic int cnt_width(input int max_len, input int width);
        int n;
        n = max_chunks(max_len, width);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-stream bundle shared by vector producer and consumer.
interface axi_stream_if #(
    parameter int DATA_W = 8
);
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/axi_write_vector.sv
// Serialises a captured bit vector into AXI-stream beats, LSB chunk first.
module axi_write_vector
    import vec_stream_pkg::*;
#(
    parameter int MAX_VEC_LENGTH = 64,
    parameter int AXI_DATA_WIDTH = 8,
    parameter int LEN_W          = $clog2(MAX_VEC_LENGTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [LEN_W-1:0]          vec_length,
    input  logic [MAX_VEC_LENGTH-1:0] vec,
    axi_stream_if.master              data_out,
    output logic                      idle,
    output logic                      done
);

    localparam int MAX_CHUNKS = max_chunks(MAX_VEC_LENGTH, AXI_DATA_WIDTH);
    localparam int CNT_W      = cnt_width(MAX_VEC_LENGTH, AXI_DATA_WIDTH);
    localparam int BUF_W      = MAX_CHUNKS * AXI_DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [BUF_W-1:0]   r_buf;
    logic [CNT_W-1:0]   r_chunk;
    logic [CNT_W-1:0]   r_last;

    logic [LEN_W-1:0]   w_eff_len;
    logic [BUF_W-1:0]   w_buf_in;
    logic [CNT_W-1:0]   w_next;
    int                 w_nchunks;

    assign w_eff_len = (vec_length > LEN_W'(MAX_VEC_LENGTH))
                     ? LEN_W'(MAX_VEC_LENGTH) : vec_length;

    // Zero everything at or above the effective length, including padding.
    always_comb begin
        w_buf_in = '0;
        w_buf_in[MAX_VEC_LENGTH-1:0] = vec;
        for (int i = 0; i < BUF_W; i++) begin
            if (i >= int'(w_eff_len)) begin
                w_buf_in[i] = 1'b0;
            end
        end
    end

    assign w_nchunks = num_chunks(int'(w_eff_len), AXI_DATA_WIDTH);
    assign w_next    = r_chunk + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_buf           <= '0;
            r_chunk         <= '0;
            r_last          <= '0;
            idle            <= 1'b1;
            done            <= 1'b0;
            data_out.tvalid <= 1'b0;
            data_out.tlast  <= 1'b0;
            data_out.tdata  <= '0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_buf   <= w_buf_in;
                        r_chunk <= '0;
                        r_last  <= CNT_W'(w_nchunks - 1);
                        idle    <= 1'b0;
                        if (w_eff_len == '0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state         <= S_SEND;
                            data_out.tvalid <= 1'b1;
                            data_out.tdata  <= w_buf_in[AXI_DATA_WIDTH-1:0];
                            data_out.tlast  <= (w_nchunks == 1);
                        end
                    end
                end
                S_SEND: begin
                    if (data_out.tready) begin
                        if (data_out.tlast) begin
                            r_state         <= S_DONE;
                            done            <= 1'b1;
                            data_out.tvalid <= 1'b0;
                            data_out.tlast  <= 1'b0;
                            data_out.tdata  <= '0;
                        end else begin
                            r_chunk        <= w_next;
                            data_out.tdata <= r_buf[int'(w_next)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                            data_out.tlast <= (w_next == r_last);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    idle    <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    idle    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_vector.sv
// Directed bench for axi_write_vector with MAX_VEC_LENGTH=20, 8-bit beats.
module tb_axi_write_vector;

    localparam int MAXL = 20;
    localparam int W    = 8;
    localparam int LW   = $clog2(MAXL + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [LW-1:0]   vec_length;
    logic [MAXL-1:0] vec;
    logic            idle;
    logic            done;

    int tests = 0;
    int fails = 0;

    axi_stream_if #(.DATA_W(W)) s_if ();

    axi_write_vector #(
        .MAX_VEC_LENGTH(MAXL),
        .AXI_DATA_WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .vec_length(vec_length),
        .vec       (vec),
        .data_out  (s_if.master),
        .idle      (idle),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [7:0] d, input logic l);
        chk({tag, "_tvalid"}, 32'(s_if.tvalid), 32'd1);
        chk({tag, "_tdata"}, 32'(s_if.tdata), 32'(d));
        chk({tag, "_tlast"}, 32'(s_if.tlast), 32'(l));
    endtask

    task automatic go(input logic [MAXL-1:0] v, input logic [LW-1:0] l);
        vec        = v;
        vec_length = l;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        vec          = '0;
        vec_length   = '0;
        s_if.tready  = 1'b1;
        step();
        step();
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tvalid", 32'(s_if.tvalid), 32'd0);
        chk("rst_tlast", 32'(s_if.tlast), 32'd0);
        chk("rst_tdata", 32'(s_if.tdata), 32'd0);
        rst = 1'b0;
        step();

        // Scenario 1 with an ignored start during SEND
        go(20'hABCDE, LW'(20));
        beat("s1_b0", 8'hDE, 1'b0);
        chk("s1_idle_send", 32'(idle), 32'd0);
        step();
        beat("s1_b1", 8'hBC, 1'b0);
        vec        = 20'h12345;
        vec_length = LW'(8);
        start      = 1'b1;
        step();
        start = 1'b0;
        beat("s1_b2", 8'h0A, 1'b1);
        step();
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_tvalid_off", 32'(s_if.tvalid), 32'd0);
        chk("s1_idle_in_done", 32'(idle), 32'd0);
        step();
        chk("s1_idle", 32'(idle), 32'd1);
        chk("s1_done_off", 32'(done), 32'd0);

        // Scenario 2: backpressure on beat 1
        go(20'hABCDE, LW'(20));
        beat("s2_b0", 8'hDE, 1'b0);
        step();
        s_if.tready = 1'b0;
        beat("s2_b1_c0", 8'hBC, 1'b0);
        step();
        beat("s2_b1_c1", 8'hBC, 1'b0);
        step();
        s_if.tready = 1'b1;
        beat("s2_b1_c2", 8'hBC, 1'b0);
        step();
        beat("s2_b2", 8'h0A, 1'b1);
        chk("s2_no_early_done", 32'(done), 32'd0);
        step();
        chk("s2_done", 32'(done), 32'd1);
        step();

        // Scenario 3: short vector with masking
        go(20'hFFFFF, LW'(5));
        beat("s3_b0", 8'h1F, 1'b1);
        step();
        chk("s3_done", 32'(done), 32'd1);
        step();

        // Mask mid-chunk across two beats
        go(20'hFFFFF, LW'(12));
        beat("m_b0", 8'hFF, 1'b0);
        step();
        beat("m_b1", 8'h0F, 1'b1);
        step();
        chk("m_done", 32'(done), 32'd1);
        step();

        // Scenario 4: zero length then over-length
        go(20'hABCDE, LW'(0));
        chk("s4_tvalid", 32'(s_if.tvalid), 32'd0);
        chk("s4_done", 32'(done), 32'd1);
        chk("s4_idle_low", 32'(idle), 32'd0);
        step();
        chk("s4_idle", 32'(idle), 32'd1);
        chk("s4_tvalid2", 32'(s_if.tvalid), 32'd0);
        go(20'hABCDE, LW'(25));
        beat("s4_b0", 8'hDE, 1'b0);
        step();
        beat("s4_b1", 8'hBC, 1'b0);
        step();
        beat("s4_b2", 8'h0A, 1'b1);
        step();
        chk("s4_done_long", 32'(done), 32'd1);
        step();

        // Scenario 6: reset mid-transfer, then fresh transfer
        go(20'hABCDE, LW'(20));
        beat("s6_b0", 8'hDE, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s6_tvalid", 32'(s_if.tvalid), 32'd0);
        chk("s6_idle", 32'(idle), 32'd1);
        chk("s6_done", 32'(done), 32'd0);
        chk("s6_tlast", 32'(s_if.tlast), 32'd0);
        go(20'h0005A, LW'(8));
        beat("s6_b", 8'h5A, 1'b1);
        step();
        chk("s6_done2", 32'(done), 32'd1);
        chk("s6_tvalid_end", 32'(s_if.tvalid), 32'd0);
        step();
        chk("s6_idle2", 32'(idle), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
